// File: rtl/pixel_array_pkg.sv
// Shared types and helpers for the pixel array sequencer and its row readout buffer.
package pixel_array_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_ROW_SEL,
    S_STREAM
  } state_t;

  // Width of the shared phase counter and of the helper function operands.
  localparam int unsigned CNT_W = 32;

  // Number of CONVERT cycles for a given pixel code width.
  function automatic logic [CNT_W-1:0] conv_len(input int unsigned w);
    return CNT_W'(1) << w;
  endfunction

  function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] b,
                                                input int unsigned      w);
    logic [CNT_W-1:0] m;
    m = (w >= CNT_W) ? '1 : ((CNT_W'(1) << w) - CNT_W'(1));
    return (b ^ (b >> 1)) & m;
  endfunction

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g,
                                                input int unsigned      w);
    logic [CNT_W-1:0] m;
    logic [CNT_W-1:0] b;
    m = (w >= CNT_W) ? '1 : ((CNT_W'(1) << w) - CNT_W'(1));
    b = g & m;
    // Prefix XOR: each bit becomes the XOR of itself and all higher Gray bits.
    for (int unsigned s = 1; s < CNT_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/pixel_row_buffer.sv
// Captures one row of column codes and streams them out column-first over valid/ready.
module pixel_row_buffer
  import pixel_array_pkg::*;
#(
  parameter int unsigned COLS   = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned GRAY   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     capture,
  input  logic                     last_row,
  input  logic [COLS*DATA_W-1:0]   col_data,
  input  logic                     pix_ready,
  output logic [DATA_W-1:0]        pix_data,
  output logic                     pix_valid,
  output logic                     pix_last,
  output logic                     row_done
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [DATA_W-1:0] rowbuf [COLS];
  logic [CW-1:0]     col;
  logic              valid;
  logic              xfer;

  assign xfer = valid & pix_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      col   <= '0;
      for (int unsigned c = 0; c < COLS; c++) begin
        rowbuf[c] <= '0;
      end
    end else if (capture) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        rowbuf[c] <= (GRAY != 0)
          ? DATA_W'(gray2bin(CNT_W'(col_data[c*DATA_W +: DATA_W]), DATA_W))
          : col_data[c*DATA_W +: DATA_W];
      end
      col   <= '0;
      valid <= 1'b1;
    end else if (xfer) begin
      if (col == COL_LAST) begin
        valid <= 1'b0;
        col   <= '0;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign pix_valid = valid;
  assign pix_data  = valid ? rowbuf[col] : '0;
  assign pix_last  = valid & last_row & (col == COL_LAST);
  assign row_done  = xfer & (col == COL_LAST);

endmodule

// File: rtl/pixel_array_ctrl.sv
// Pixel array phase sequencer: erase, expose, ramp conversion, then row-by-row readout.
module pixel_array_ctrl
  import pixel_array_pkg::*;
#(
  parameter int unsigned ROWS         = 2,
  parameter int unsigned COLS         = 2,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ERASE_CYCLES = 5,
  parameter int unsigned READ_SETTLE  = 2,
  parameter int unsigned GRAY         = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   cont,
  input  logic [15:0]            expose_len,
  output logic                   erase,
  output logic                   expose,
  output logic                   ramp_en,
  output logic [DATA_W-1:0]      cnt_out,
  output logic                   cnt_oe,
  output logic [ROWS-1:0]        read,
  input  logic [COLS*DATA_W-1:0] col_data,
  output logic [DATA_W-1:0]      pix_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   pix_last,
  output logic                   busy
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] CONV_LAST   = conv_len(DATA_W) - CNT_W'(1);
  localparam logic [CNT_W-1:0] ERASE_LAST  = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(READ_SETTLE - 1);
  localparam logic [RW-1:0]    ROW_LAST    = RW'(ROWS - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] exp_last;
  logic [RW-1:0]    row;
  logic [15:0]      exp_len;
  logic             cont_q;
  logic             capture;
  logic             row_done;
  logic             last_row;

  assign last_row = (row == ROW_LAST);
  assign exp_last = CNT_W'(exp_len) - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      row     <= '0;
      exp_len <= '0;
      cont_q  <= 1'b0;
    end else begin
      state <= state_nx;
      // Phase counter restarts at every phase boundary and idles at zero.
      if (state_nx != state || state == S_IDLE || state == S_STREAM) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state == S_IDLE && start) begin
        cont_q  <= cont;
        exp_len <= (expose_len == 16'd0) ? 16'd1 : expose_len;
      end else if (state == S_STREAM && row_done && last_row) begin
        cont_q <= cont_q & cont;
      end
      if (state == S_CONVERT) begin
        row <= '0;
      end else if (state == S_STREAM && row_done && !last_row) begin
        row <= row + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start)                 state_nx = S_ERASE;
      S_ERASE:   if (cnt == ERASE_LAST)     state_nx = S_EXPOSE;
      S_EXPOSE:  if (cnt == exp_last)       state_nx = S_CONVERT;
      S_CONVERT: if (cnt == CONV_LAST)      state_nx = S_ROW_SEL;
      S_ROW_SEL: if (cnt == SETTLE_LAST)    state_nx = S_STREAM;
      S_STREAM: begin
        if (row_done) begin
          if (!last_row)          state_nx = S_ROW_SEL;
          else if (cont_q && cont) state_nx = S_ERASE;
          else                     state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    erase   = (state == S_ERASE);
    expose  = (state == S_EXPOSE);
    ramp_en = (state == S_CONVERT);
    cnt_oe  = (state == S_CONVERT);
    busy    = (state != S_IDLE);
    cnt_out = '0;
    read    = '0;
    capture = 1'b0;
    if (state == S_CONVERT) begin
      cnt_out = (GRAY != 0) ? DATA_W'(bin2gray(CNT_W'(cnt[DATA_W-1:0]), DATA_W))
                            : cnt[DATA_W-1:0];
    end
    if (state == S_ROW_SEL) begin
      read    = ROWS'(1) << row;
      capture = (cnt == SETTLE_LAST);
    end
  end

  pixel_row_buffer #(
    .COLS   (COLS),
    .DATA_W (DATA_W),
    .GRAY   (GRAY)
  ) u_row_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .last_row  (last_row),
    .col_data  (col_data),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_last  (pix_last),
    .row_done  (row_done)
  );

endmodule

// File: doc/pixel_array_ctrl.md
# pixel_array_ctrl

Digital sequencer and readout engine for a parametrised ROWS×COLS pixel sensor array.
- Runs the pixel phases in order: erase, expose, convert and read.
- During convert it drives the shared ramp-conversion counter.
- During read it selects rows one at a time, captures the COLS column buses and streams the pixels out over a valid/ready interface.
- It replaces hand-driven per-pixel READ strobes, adds optional Gray-coded conversion and adds a continuous-frame mode.

## Interface
Parameters:
- ROWS, 2: number of pixel rows; each row has its own read strobe.
- COLS, 2: number of column data buses.
- DATA_W, 8: pixel code width.
- ERASE_CYCLES, 5: erase phase length; must be ≥1.
- READ_SETTLE, 2: cycles the read strobe is held before capture; must be ≥1.
- GRAY, 1: when 1, the counter is Gray-coded on the bus and captured codes are converted back to binary.

Ports:
- clk, in, 1: single clock. All logic is on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- start, in, 1: frame request; sampled only in IDLE.
- cont, in, 1: continuous mode; latched with start.
- expose_len, in, 16: exposure length in cycles; latched with start. A value of 0 is treated as 1.
- erase, out, 1: pixel erase.
- expose, out, 1: pixel expose.
- ramp_en, out, 1: starts the analog ramp; high during CONVERT.
- cnt_out, out, DATA_W: conversion counter driven onto the column buses.
- cnt_oe, out, 1: counter output enable (drives the external tristate); high during CONVERT.
- read, out, ROWS: one-hot row read strobe.
- col_data, in, COLS*DATA_W: column buses; column c is at [c*DATA_W +: DATA_W].
- pix_data, out, DATA_W: binary pixel value.
- pix_valid, out, 1: stream valid.
- pix_ready, in, 1: stream ready.
- pix_last, out, 1: marks the final pixel of the frame.
- busy, out, 1: high whenever the state is not IDLE.

## Operation
- Reset: state = IDLE. All outputs are 0, and all counters and latched configuration are cleared. Reset mid-frame aborts the frame; any pending beat is dropped.
- States: IDLE, ERASE, EXPOSE, CONVERT, ROW_SEL, STREAM.
- IDLE: when start=1, latch cont and expose_len, then go to ERASE.
- ERASE: erase=1 for ERASE_CYCLES cycles, then go to EXPOSE.
- EXPOSE: expose=1 for max(expose_len,1) cycles, then go to CONVERT.
- CONVERT:
  - ramp_en=1 and cnt_oe=1 for exactly 2^DATA_W cycles.
  - Binary count b runs 0…2^DATA_W−1, one step per cycle.
  - cnt_out = GRAY ? b^(b>>1) : b.
  - Then go to ROW_SEL with row=0. The counter does not wrap into a second pass.
- ROW_SEL:
  - read[row]=1 for READ_SETTLE cycles.
  - On the edge ending the last of those cycles, all COLS codes are captured into the row buffer (converted Gray→binary if GRAY=1).
  - read returns to 0, then go to STREAM.
- STREAM:
  - Emits COLS beats in order, column 0 first.
  - A beat transfers when pix_valid and pix_ready are both 1. pix_valid stays high and pix_data/pix_last stay stable until transfer.
  - pix_last=1 only on column COLS−1 of row ROWS−1.
  - After the last beat of a row: if row<ROWS−1, go to ROW_SEL with row+1. Otherwise go to ERASE if cont=1, else IDLE.
- cont is re-sampled live at frame end. Dropping cont mid-frame lets the current frame finish, then the block returns to IDLE.
- start is ignored while busy.
- read is never active outside ROW_SEL and is always one-hot or zero. erase, expose and cnt_oe are never high together.

## Timing
- start sampled high at edge k: busy=1 and erase=1 from cycle k+1.
- Phase boundaries are back-to-back with no idle gaps.
- First pix_valid appears the cycle after capture.
- With pix_ready tied to 1, frame time = ERASE_CYCLES + max(expose_len,1) + 2^DATA_W + ROWS*(READ_SETTLE+COLS) cycles.
- busy falls the cycle after the final transfer when cont=0.
- pix_ready low for N cycles stalls STREAM by exactly N cycles; there is no data loss.

## Structure
- pixel_array_pkg holds:
  - the state enum typedef;
  - bin2gray and gray2bin functions, parametrised by width;
  - a localparam for the CONVERT length.
- Sub-module pixel_row_buffer (COLS, DATA_W) covers capture, Gray decode, column index, valid/ready handshake and last-beat flag. It reports row done to the top FSM.

## Test plan
- Default parameters, start pulse, expose_len=10, pix_ready=1, col_data fixed at Gray(0x12) on column 0 and Gray(0x34) on column 1:
  - erase lasts 5 cycles, expose 10, convert 256 (cnt_out sequence 0,1,3,2,…);
  - then 4 beats 0x12, 0x34, 0x12, 0x34, with pix_last on the 4th;
  - busy falls afterwards.
- expose_len=0: expose is high for exactly 1 cycle.
- pix_ready toggling 1/0 during STREAM: pix_data stays stable while stalled, and the beat count is still 4 with no duplicates.
- cont=1 through two frames, dropped during the second: a new erase follows frame 1 immediately, and the block goes to IDLE after frame 2.
- rst_n low in mid-CONVERT and again mid-STREAM: all outputs are 0 on the next cycle and state is IDLE; the next start runs a full clean frame.
- GRAY=0 with ROWS=3, COLS=4: the binary counter runs 0…255, read is one-hot per row, and the bench receives 12 beats in row-major order.
